// File: rtl/mem_access_unit.sv
// Memory-access stage: MIPS loads/stores over a variable-latency req/ack bus.
// Non-memory ops pass Result through; misaligned accesses and bus timeouts flag mem_err.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Ins,
    input  logic [ADDR_W-1:0] Result,
    input  logic [31:0]       Rdata2,
    output logic              out_valid,
    output logic [31:0]       Wdata,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic {IDLE, BUS} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    size_t          sz_q, sz_d;
    logic           sgn_q, sgn_d;
    logic           st_q, st_d;
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    res_q, res_d;

    logic           ov_d, err_d, req_d, we_d;
    logic [31:0]    wdata_d, bwd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]     be_d;

    logic           is_mem, is_st, is_sgn, misalign;
    size_t          is_sz;
    logic [31:0]    res32;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [31:0]    load_v;
    logic           unused_ins;

    assign unused_ins = ^Ins[25:0];

    generate
        if (ADDR_W >= 32) begin : g_trunc
            assign res32 = Result[31:0];
        end else begin : g_zext
            assign res32 = {{(32 - ADDR_W){1'b0}}, Result};
        end
    endgenerate

    // Opcode decode into size, signedness and direction
    always_comb begin
        is_mem = 1'b1;
        is_st  = 1'b0;
        is_sgn = 1'b0;
        is_sz  = SZ_W;
        unique case (Ins[31:26])
            6'h20: begin is_sz = SZ_B; is_sgn = 1'b1; end
            6'h21: begin is_sz = SZ_H; is_sgn = 1'b1; end
            6'h23: is_sz = SZ_W;
            6'h24: is_sz = SZ_B;
            6'h25: is_sz = SZ_H;
            6'h28: begin is_sz = SZ_B; is_st = 1'b1; end
            6'h29: begin is_sz = SZ_H; is_st = 1'b1; end
            6'h2B: begin is_sz = SZ_W; is_st = 1'b1; end
            default: is_mem = 1'b0;
        endcase
    end

    assign misalign = ((is_sz == SZ_H) && Result[0]) ||
                      ((is_sz == SZ_W) && (Result[1:0] != 2'b00));

    // Big-endian lane select and extension of the returned word
    always_comb begin
        unique case (lane_q)
            2'd0:    byte_v = bus_rdata[31:24];
            2'd1:    byte_v = bus_rdata[23:16];
            2'd2:    byte_v = bus_rdata[15:8];
            default: byte_v = bus_rdata[7:0];
        endcase
        half_v = lane_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        unique case (sz_q)
            SZ_B:    load_v = {{24{sgn_q & byte_v[7]}}, byte_v};
            SZ_H:    load_v = {{16{sgn_q & half_v[15]}}, half_v};
            default: load_v = bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sz_d    = sz_q;
        sgn_d   = sgn_q;
        st_d    = st_q;
        lane_d  = lane_q;
        res_d   = res_q;
        ov_d    = 1'b0;
        err_d   = 1'b0;
        wdata_d = Wdata;
        req_d   = bus_req;
        we_d    = bus_we;
        addr_d  = bus_addr;
        be_d    = bus_be;
        bwd_d   = bus_wdata;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        ov_d    = 1'b1;
                        wdata_d = res32;
                    end else if (misalign) begin
                        ov_d    = 1'b1;
                        err_d   = 1'b1;
                        wdata_d = '0;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                        sz_d    = is_sz;
                        sgn_d   = is_sgn;
                        st_d    = is_st;
                        lane_d  = Result[1:0];
                        res_d   = res32;
                        req_d   = 1'b1;
                        we_d    = is_st;
                        addr_d  = {Result[ADDR_W-1:2], 2'b00};
                        unique case (is_sz)
                            SZ_B: begin
                                be_d  = 4'b1000 >> Result[1:0];
                                bwd_d = {4{Rdata2[7:0]}};
                            end
                            SZ_H: begin
                                be_d  = Result[1] ? 4'b0011 : 4'b1100;
                                bwd_d = {2{Rdata2[15:0]}};
                            end
                            default: begin
                                be_d  = 4'b1111;
                                bwd_d = Rdata2;
                            end
                        endcase
                        if (!is_st) bwd_d = '0;
                    end
                end
            end
            default: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    wdata_d = st_q ? res_q : load_v;
                end else if (TIMEOUT_CYC != 0 && cnt == LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    err_d   = 1'b1;
                    wdata_d = '0;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            sz_q      <= SZ_W;
            sgn_q     <= 1'b0;
            st_q      <= 1'b0;
            lane_q    <= 2'b00;
            res_q     <= '0;
            out_valid <= 1'b0;
            mem_err   <= 1'b0;
            Wdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sz_q      <= sz_d;
            sgn_q     <= sgn_d;
            st_q      <= st_d;
            lane_q    <= lane_d;
            res_q     <= res_d;
            out_valid <= ov_d;
            mem_err   <= err_d;
            Wdata     <= wdata_d;
            bus_req   <= req_d;
            bus_we    <= we_d;
            bus_addr  <= addr_d;
            bus_be    <= be_d;
            bus_wdata <= bwd_d;
        end
    end

    assign in_ready = (state == IDLE);

endmodule
